// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor: rate-coded view of a neuron spike train.
// Detects spike onsets, counts them per fixed window of enabled cycles, hands
// each finished window count to the readout over valid/ready, and measures the
// onset-to-onset interval (ISI).
module spike_rate_monitor #(
   parameter int unsigned WINDOW_CYCLES = 256,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned ISI_W         = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             spike,
   input  logic             enable,
   output logic [CNT_W-1:0] rate,
   output logic             rate_sat,
   output logic             rate_valid,
   input  logic             rate_ready,
   output logic             overrun,
   output logic [ISI_W-1:0] isi,
   output logic             isi_valid
);

   localparam int unsigned      WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Saturating increment for the per-window spike count.
   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_W'(1'b1);
      end
      return r;
   endfunction

   // Saturating increment for the interval timer and the reported interval.
   function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] v);
      logic [ISI_W-1:0] r;
      if (v == ISI_MAX) begin
         r = v;
      end else begin
         r = v + ISI_W'(1'b1);
      end
      return r;
   endfunction

   // Datapath state
   logic             spike_q;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sat_q, sat_d;
   logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
   logic             armed_q, armed_d;
   logic [ISI_W-1:0] isi_q, isi_d;
   logic             isi_valid_q, isi_valid_d;

   // Output FSM state and registered outputs
   state_e           state_q;
   logic [CNT_W-1:0] rate_q;
   logic             rate_sat_q;
   logic             rate_valid_q;
   logic             overrun_q;

   // Combinational helpers
   logic             event_s;
   logic             cnt_event_s;
   logic             close_s;
   logic [CNT_W-1:0] final_count_s;
   logic             final_sat_s;

   // Onset detection, window close detection and the closing-window result.
   always_comb begin
      event_s       = spike & ~spike_q;
      cnt_event_s   = enable & event_s;
      close_s       = enable & (win_cnt_q == WIN_LAST);
      final_count_s = count_q;
      final_sat_s   = sat_q;
      if (cnt_event_s) begin
         final_count_s = cnt_sat_inc(count_q);
         final_sat_s   = sat_q | (count_q == CNT_MAX);
      end else begin
         final_count_s = count_q;
         final_sat_s   = sat_q;
      end
   end

   // Next state for the window counter and per-window count/saturation.
   always_comb begin
      win_cnt_d = win_cnt_q;
      count_d   = count_q;
      sat_d     = sat_q;
      if (close_s) begin
         win_cnt_d = {WIN_W{1'b0}};
         count_d   = {CNT_W{1'b0}};
         sat_d     = 1'b0;
      end else if (enable) begin
         win_cnt_d = win_cnt_q + WIN_W'(1'b1);
         count_d   = final_count_s;
         sat_d     = final_sat_s;
      end else begin
         win_cnt_d = win_cnt_q;
         count_d   = count_q;
         sat_d     = sat_q;
      end
   end

   // Next state for the interval timer; the first onset only arms it.
   always_comb begin
      isi_cnt_d   = isi_cnt_q;
      armed_d     = armed_q;
      isi_d       = isi_q;
      isi_valid_d = isi_valid_q;
      if (event_s) begin
         isi_cnt_d = {ISI_W{1'b0}};
         armed_d   = 1'b1;
         if (armed_q) begin
            isi_d       = isi_sat_inc(isi_cnt_q);
            isi_valid_d = 1'b1;
         end else begin
            isi_d       = isi_q;
            isi_valid_d = isi_valid_q;
         end
      end else begin
         isi_cnt_d   = isi_sat_inc(isi_cnt_q);
         armed_d     = armed_q;
         isi_d       = isi_q;
         isi_valid_d = isi_valid_q;
      end
   end

   // Datapath registers; reset discards any partial window and disarms the ISI.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         spike_q     <= 1'b0;
         win_cnt_q   <= {WIN_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         sat_q       <= 1'b0;
         isi_cnt_q   <= {ISI_W{1'b0}};
         armed_q     <= 1'b0;
         isi_q       <= {ISI_W{1'b0}};
         isi_valid_q <= 1'b0;
      end else begin
         spike_q     <= spike;
         win_cnt_q   <= win_cnt_d;
         count_q     <= count_d;
         sat_q       <= sat_d;
         isi_cnt_q   <= isi_cnt_d;
         armed_q     <= armed_d;
         isi_q       <= isi_d;
         isi_valid_q <= isi_valid_d;
      end
   end

   // Output FSM: one-deep result buffer; a close while unconsumed is dropped and flagged.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_EMPTY;
         rate_q       <= {CNT_W{1'b0}};
         rate_sat_q   <= 1'b0;
         rate_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (close_s) begin
                  rate_q       <= final_count_s;
                  rate_sat_q   <= final_sat_s;
                  rate_valid_q <= 1'b1;
                  state_q      <= ST_FULL;
               end else begin
                  rate_valid_q <= 1'b0;
                  state_q      <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (close_s) begin
                  if (rate_ready) begin
                     // Consumer takes the old result as the new one arrives.
                     rate_q     <= final_count_s;
                     rate_sat_q <= final_sat_s;
                  end else begin
                     overrun_q  <= 1'b1;
                  end
                  rate_valid_q <= 1'b1;
                  state_q      <= ST_FULL;
               end else if (rate_ready) begin
                  rate_valid_q <= 1'b0;
                  state_q      <= ST_EMPTY;
               end else begin
                  rate_valid_q <= 1'b1;
                  state_q      <= ST_FULL;
               end
            end
            default: begin
               rate_valid_q <= 1'b0;
               state_q      <= ST_EMPTY;
            end
         endcase
      end
   end

   assign rate       = rate_q;
   assign rate_sat   = rate_sat_q;
   assign rate_valid = rate_valid_q;
   assign overrun    = overrun_q;
   assign isi        = isi_q;
   assign isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor. Instance a: 16-cycle windows, 2-bit
// count. Instance b shares the stimulus with an 8-bit count and a 4-bit ISI.
module tb_spike_rate_monitor;

   logic        clk;
   logic        reset_n;
   logic        spike;
   logic        enable;
   logic        rate_ready;

   logic [1:0]  rate_a;
   logic        rate_sat_a, rate_valid_a, overrun_a, isi_valid_a;
   logic [15:0] isi_a;

   logic [7:0]  rate_b;
   logic        rate_sat_b, rate_valid_b, overrun_b, isi_valid_b;
   logic [3:0]  isi_b;

   int checks = 0;
   int errors = 0;

   spike_rate_monitor #(.WINDOW_CYCLES(16), .CNT_W(2), .ISI_W(16)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .spike(spike), .enable(enable),
      .rate(rate_a), .rate_sat(rate_sat_a), .rate_valid(rate_valid_a),
      .rate_ready(rate_ready), .overrun(overrun_a),
      .isi(isi_a), .isi_valid(isi_valid_a)
   );

   spike_rate_monitor #(.WINDOW_CYCLES(16), .CNT_W(8), .ISI_W(4)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .spike(spike), .enable(enable),
      .rate(rate_b), .rate_sat(rate_sat_b), .rate_valid(rate_valid_b),
      .rate_ready(rate_ready), .overrun(overrun_b),
      .isi(isi_b), .isi_valid(isi_valid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hold spike at sp for n clock edges; returns 1 time unit after the last edge.
   task automatic run(input int n, input logic sp);
      spike = sp;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      enable     = 1'b0;
      spike      = 1'b0;
      rate_ready = 1'b0;
      run(2, 1'b0);
      chk("reset_rate",       32'(rate_a),       32'd0);
      chk("reset_rate_valid", 32'(rate_valid_a), 32'd0);
      chk("reset_overrun",    32'(overrun_a),    32'd0);
      chk("reset_isi_valid",  32'(isi_valid_a),  32'd0);

      // Window 1: single-cycle pulses at window cycles 2, 5, 9.
      reset_n = 1'b1; enable = 1'b1; rate_ready = 1'b1;
      run(2, 1'b0); run(1, 1'b1); run(2, 1'b0); run(1, 1'b1);
      run(3, 1'b0); run(1, 1'b1); run(5, 1'b0);
      chk("w1_valid_before_close", 32'(rate_valid_a), 32'd0);
      run(1, 1'b0);
      chk("w1_rate",      32'(rate_a),       32'd3);
      chk("w1_rate_sat",  32'(rate_sat_a),   32'd0);
      chk("w1_valid",     32'(rate_valid_a), 32'd1);
      chk("w1_overrun",   32'(overrun_a),    32'd0);
      chk("w1_isi",       32'(isi_a),        32'd4);
      chk("w1_isi_valid", 32'(isi_valid_a),  32'd1);
      run(1, 1'b0);
      chk("w1_valid_one_cycle", 32'(rate_valid_a), 32'd0);

      // Window 2: spike held high for 10 cycles from cycle 1.
      run(1, 1'b1);
      chk("w2_isi_across_windows", 32'(isi_a), 32'd8);
      run(9, 1'b1); run(5, 1'b0);
      chk("w2_held_rate",  32'(rate_a),       32'd1);
      chk("w2_held_valid", 32'(rate_valid_a), 32'd1);

      // Window 3: next onset 20 cycles later, then six onsets total incl. close cycle.
      run(5, 1'b0); run(1, 1'b1);
      chk("w3_isi20",       32'(isi_a),       32'd20);
      chk("w3_isi20_valid", 32'(isi_valid_a), 32'd1);
      chk("w3_isi_b_sat",   32'(isi_b),       32'd15);
      for (int k = 0; k < 4; k++) begin
         run(1, 1'b0); run(1, 1'b1);
      end
      run(1, 1'b0); run(1, 1'b1);
      chk("w3_sat_rate",     32'(rate_a),     32'd3);
      chk("w3_sat_flag",     32'(rate_sat_a), 32'd1);
      chk("w3_b_rate6",      32'(rate_b),     32'd6);
      chk("w3_b_sat",        32'(rate_sat_b), 32'd0);
      chk("w3_isi_min",      32'(isi_a),      32'd2);

      // Window 4: empty; result held while not ready, ready exactly on close.
      rate_ready = 1'b0;
      run(15, 1'b0);
      chk("w4_hold_valid", 32'(rate_valid_a), 32'd1);
      chk("w4_hold_rate",  32'(rate_a),       32'd3);
      chk("w4_hold_sat",   32'(rate_sat_a),   32'd1);
      rate_ready = 1'b1;
      run(1, 1'b0);
      chk("w4_close_ready_valid",   32'(rate_valid_a), 32'd1);
      chk("w4_empty_rate",          32'(rate_a),       32'd0);
      chk("w4_empty_sat",           32'(rate_sat_a),   32'd0);
      chk("w4_close_ready_overrun", 32'(overrun_a),    32'd0);

      // Windows 5 and 6: not ready through two closes.
      rate_ready = 1'b0;
      run(3, 1'b0); run(1, 1'b1); run(12, 1'b0);
      chk("w5_overrun",   32'(overrun_a),    32'd1);
      chk("w5_held_rate", 32'(rate_a),       32'd0);
      chk("w5_valid",     32'(rate_valid_a), 32'd1);
      run(3, 1'b0); run(1, 1'b1); run(4, 1'b0); run(1, 1'b1); run(7, 1'b0);
      chk("w6_held_rate", 32'(rate_a),    32'd0);
      chk("w6_overrun",   32'(overrun_a), 32'd1);
      rate_ready = 1'b1;
      run(1, 1'b0);
      chk("w7_drain_valid",     32'(rate_valid_a), 32'd0);
      chk("w7_overrun_sticky",  32'(overrun_a),    32'd1);

      // Window 7: onset at cycle 2, then 8 disabled cycles with two onsets.
      run(1, 1'b0); run(1, 1'b1); run(1, 1'b0);
      enable = 1'b0;
      run(2, 1'b0); run(1, 1'b1); run(2, 1'b0); run(1, 1'b1);
      chk("w7_disabled_isi",       32'(isi_a),       32'd3);
      chk("w7_disabled_isi_valid", 32'(isi_valid_a), 32'd1);
      run(2, 1'b0);
      enable = 1'b1;
      run(11, 1'b0);
      chk("w7_no_early_close", 32'(rate_valid_a), 32'd0);
      run(1, 1'b0);
      chk("w7_late_close_valid", 32'(rate_valid_a), 32'd1);
      chk("w7_disabled_rate",    32'(rate_a),       32'd1);

      // Window 8: two onsets, result pending, then reset mid-window.
      rate_ready = 1'b0;
      run(1, 1'b0); run(1, 1'b1); run(2, 1'b0); run(1, 1'b1); run(2, 1'b0);
      chk("w8_pending_valid", 32'(rate_valid_a), 32'd1);
      reset_n = 1'b0;
      run(1, 1'b0);
      chk("rst2_rate",       32'(rate_a),       32'd0);
      chk("rst2_rate_sat",   32'(rate_sat_a),   32'd0);
      chk("rst2_rate_valid", 32'(rate_valid_a), 32'd0);
      chk("rst2_overrun",    32'(overrun_a),    32'd0);
      chk("rst2_isi",        32'(isi_a),        32'd0);
      chk("rst2_isi_valid",  32'(isi_valid_a),  32'd0);
      reset_n = 1'b1; rate_ready = 1'b1;

      // Window 9: fresh window, first onset only arms the ISI.
      run(2, 1'b0); run(1, 1'b1);
      chk("w9_first_onset_isi_valid", 32'(isi_valid_a), 32'd0);
      run(12, 1'b0); run(1, 1'b0);
      chk("w9_rate_from_zero", 32'(rate_a),       32'd1);
      chk("w9_valid",          32'(rate_valid_a), 32'd1);
      chk("w9_isi_still_idle", 32'(isi_valid_a),  32'd0);

      // Window 10: second post-reset onset produces the first measurement.
      run(3, 1'b0); run(1, 1'b1);
      chk("w10_isi",       32'(isi_a),       32'd17);
      chk("w10_isi_valid", 32'(isi_valid_a), 32'd1);
      run(1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
